// File: rtl/store_unit.sv
// store_unit: turns a STORE instruction (opcode, funct3, effective address,
// rs2 data) into a single word-aligned data-memory write request. The unit
// drives byte-lane enables and lane-replicated write data, and holds the
// request until mem_ack arrives or TIMEOUT_CYCLES elapse. It then pulses
// done (with err on failure) for one cycle.
//
// Optional build macro: STORE_MISALIGN_TRAP_EN
//   defined   -> SH with addr[0]=1 or SW with addr[1:0]!=0 completes with err=1
//                and never raises mem_req.
//   undefined -> low address bits that do not select a lane are ignored.
module store_unit #(
    parameter int         ADDR_W         = 32,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [6:0] STORE_OPCODE   = 7'b0100011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        op_code,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rs2_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_be_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic                op_ok_s;
    logic                f3_ok_s;
    logic                misalign_s;
    logic                accept_s;

    // Byte-lane enables for a given store width and address offset.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << lo;
            3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store data across lanes so every enabled lane sees it.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{d[7:0]}};
            3'b001:  w = {2{d[15:0]}};
            3'b010:  w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Decode whether the presented instruction is an acceptable store.
    always_comb begin
        op_ok_s    = (op_code == STORE_OPCODE);
        f3_ok_s    = 1'b0;
        misalign_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
            default:                f3_ok_s = 1'b0;
        endcase
`ifdef STORE_MISALIGN_TRAP_EN
        case (funct3)
            3'b001:  misalign_s = addr[0];
            3'b010:  misalign_s = (addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
        if (op_ok_s && f3_ok_s && !misalign_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next value of the no-ack cycle counter while a request is outstanding.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    cnt_q  <= '0;
                    if (start) begin
                        if (accept_s) begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            busy_q      <= 1'b1;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= lane_wdata(funct3, rs2_data);
                            mem_be_q    <= lane_be(funct3, addr[1:0]);
                        end else begin
                            // Rejected stores finish immediately, memory untouched.
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q   <= FIN;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_d == CNT_LAST) begin
                        state_q   <= FIN;
                        mem_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                FIN: begin
                    // done/err were raised on entry; drop them and ignore start.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: each driven store pushes its expected
// request/completion; a negedge monitor compares memory-side outputs and pops
// on done.
module tb_store_unit;

    localparam int          TO       = 16;
    localparam logic [6:0]  STORE_OP = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  op_code = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic        has_req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        int          req_cycles;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   req_cnt = 0;

    store_unit #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(TO),
        .STORE_OPCODE(STORE_OP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
        .funct3(funct3), .addr(addr), .rs2_data(rs2_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference model of one store.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d, input int dly);
        exp_t e;
        bit   ok;
        ok = (op == STORE_OP) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
`ifdef STORE_MISALIGN_TRAP_EN
        if (f3 == 3'b001 && a[0]) ok = 1'b0;
        if (f3 == 3'b010 && a[1:0] != 2'b00) ok = 1'b0;
`endif
        e.addr = {a[31:2], 2'b00};
        if (f3 == 3'b000) begin
            e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
            case (a[1:0])
                2'd0: e.be = 4'b0001;
                2'd1: e.be = 4'b0010;
                2'd2: e.be = 4'b0100;
                default: e.be = 4'b1000;
            endcase
        end else if (f3 == 3'b001) begin
            e.wdata = {d[15:0], d[15:0]};
            e.be    = a[1] ? 4'b1100 : 4'b0011;
        end else begin
            e.wdata = d;
            e.be    = 4'b1111;
        end
        if (!ok) begin
            e.has_req = 1'b0; e.err = 1'b1; e.req_cycles = 0; e.lat = 1;
        end else if (dly < 0 || dly >= TO) begin
            e.has_req = 1'b1; e.err = 1'b1; e.req_cycles = TO; e.lat = TO + 1;
        end else begin
            e.has_req = 1'b1; e.err = 1'b0; e.req_cycles = dly + 1; e.lat = dly + 2;
        end
        return e;
    endfunction

    // Monitor: compare request fields each REQ cycle, retire on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            req_cnt = 0;
        end else begin
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    check("req_unexpected", 64'(mem_req), 64'd0);
                end else begin
                    e = exp_q[0];
                    check("req_allowed", 64'(e.has_req), 64'd1);
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("mem_be", 64'(mem_be), 64'(e.be));
                    check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    check("busy_in_req", 64'(busy), 64'd1);
                    req_cnt++;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err", 64'(err), 64'(e.err));
                    check("req_cycles", 64'(req_cnt), 64'(e.req_cycles));
                    check("busy_at_done", 64'(busy), 64'd0);
                    check("req_at_done", 64'(mem_req), 64'd0);
                end
                req_cnt = 0;
            end
            if (err && !done) check("err_without_done", 64'(err), 64'd0);
        end
    end

    task automatic run_store(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input int dly, input bit poke_busy,
                             input bit poke_fin);
        exp_t e;
        int   lat;
        bit   seen;
        e = model(op, f3, a, d, dly);
        @(posedge clk); #1;
        op_code = op; funct3 = f3; addr = a; rs2_data = d; start = 1'b1;
        exp_q.push_back(e);
        lat = 0; seen = 1'b0;
        for (int c = 1; c <= TO + 8 && !seen; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (poke_busy && c == 2) begin
                start = 1'b1; op_code = STORE_OP; funct3 = 3'b010;
                addr = a ^ 32'h0000_0104; rs2_data = ~d;
            end
            mem_ack = (dly >= 0 && c == dly + 1);
            @(negedge clk);
            if (done) begin
                seen = 1'b1; lat = c;
            end
        end
        mem_ack = 1'b0;
        start = 1'b0;
        if (!seen) begin
            check("done_never_seen", 64'd0, 64'd1);
        end else begin
            check("done_latency", 64'(lat), 64'(e.lat));
            if (poke_fin) begin
                start = 1'b1; op_code = STORE_OP; funct3 = 3'b010;
                addr = 32'h0000_0040; rs2_data = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset held with a valid start present.
        rst_n = 1'b0; start = 1'b1; op_code = STORE_OP; funct3 = 3'b010; addr = 32'h100;
        rs2_data = 32'h1111_2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_req", 64'(mem_req), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Directed cases.
        run_store(STORE_OP, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1'b0, 1'b1);
        run_store(STORE_OP, 3'b001, 32'h0000_2002, 32'h1234_5678, 3, 1'b1, 1'b0);
        run_store(7'b0000011, 3'b000, 32'h0000_3000, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        run_store(STORE_OP, 3'b011, 32'h0000_3004, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        run_store(STORE_OP, 3'b010, 32'h0000_0010, 32'h89AB_CDEF, -1, 1'b0, 1'b0);
        // Late ack while idle must be ignored.
        @(posedge clk); #1; mem_ack = 1'b1;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", 64'(mem_req), 64'd0);
        check("late_ack_busy", 64'(busy), 64'd0);
        run_store(STORE_OP, 3'b010, 32'h0000_0022, 32'h0BAD_F00D, 1, 1'b0, 1'b0);
        run_store(STORE_OP, 3'b001, 32'h0000_0051, 32'h0000_ABCD, 2, 1'b0, 1'b0);
        run_store(STORE_OP, 3'b000, 32'h0000_0062, 32'h0000_0077, TO - 1, 1'b0, 1'b0);

        // Random mix of valid stores.
        for (int i = 0; i < 10; i++) begin
            run_store(STORE_OP, 3'($urandom_range(0, 2)), $urandom, $urandom,
                      int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end

        // Reset in the middle of a request: no done may follow.
        e = model(STORE_OP, 3'b010, 32'h0000_0400, 32'h5555_AAAA, -1);
        @(posedge clk); #1;
        op_code = STORE_OP; funct3 = 3'b010; addr = 32'h0000_0400; rs2_data = 32'h5555_AAAA;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("midrst_req", 64'(mem_req), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_quiet", 64'({mem_req, busy, done}), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
